// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - MD op encodings, FSM states and default latencies
// Purpose: shared definitions for the multiply/divide unit and the controller
//          that drives its md_op input.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  // Operations that launch a busy period.
  function automatic logic md_is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - EX-stage multiply/divide unit with HI/LO register pair
// Purpose: executes mult/multu/div/divu with a fixed busy latency, plus
//          mthi/mtlo writes and combinational mfhi/mflo reads.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - one-cycle launch pulse for an arithmetic md_op
//   md_op   - operation code (md_op_e)
//   rs_val  - rs operand (dividend / multiplicand / mthi-mtlo source)
//   rt_val  - rt operand (divisor / multiplier)
//   busy    - operation in flight
//   md_out  - HI for MFHI, LO for MFLO, else 0
//   hi, lo  - architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_nxt_q, lo_nxt_q;
  logic [31:0] hi_q, lo_q;

  md_op_e      op;
  logic        launch;
  logic [31:0] res_hi_d, res_lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor, quot_s, rem_s, quot_u, rem_u;
  logic               div_zero, div_ovf;

  assign op     = md_op_e'(md_op);
  assign launch = start && md_is_arith(op);

  always_comb begin
    prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    // The only signed quotient that does not fit in 32 bits.
    div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    // Substitute divisor keeps the divider free of X when rt is zero;
    // that result is never selected.
    divisor  = div_zero ? 32'd1 : rt_val;
    quot_s   = 32'($signed(rs_val) / $signed(divisor));
    rem_s    = 32'($signed(rs_val) % $signed(divisor));
    quot_u   = rs_val / divisor;
    rem_u    = rs_val % divisor;

    // Divide by zero latches the current HI/LO so the commit is a no-op;
    // HI/LO cannot change during RUN, so this equals "left unchanged".
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    case (op)
      MD_MULT:  {res_hi_d, res_lo_d} = prod_s;
      MD_MULTU: {res_hi_d, res_lo_d} = prod_u;
      MD_DIV: begin
        if (div_ovf) begin
          res_hi_d = 32'd0;
          res_lo_d = 32'h8000_0000;
        end else if (!div_zero) begin
          res_hi_d = rem_s;
          res_lo_d = quot_s;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          res_hi_d = rem_u;
          res_lo_d = quot_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= 4'd0;
      hi_nxt_q <= 32'd0;
      lo_nxt_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (launch) begin
            hi_nxt_q <= res_hi_d;
            lo_nxt_q <= res_lo_d;
            cnt_q    <= ((op == MD_MULT) || (op == MD_MULTU)) ? 4'(MULT_CYCLES)
                                                              : 4'(DIV_CYCLES);
            state_q  <= MD_RUN;
          end else if (op == MD_MTHI) begin
            hi_q <= rs_val;
          end else if (op == MD_MTLO) begin
            lo_q <= rs_val;
          end
        end
        MD_RUN: begin
          // start/mthi/mtlo are deliberately ignored here.
          if (cnt_q == 4'd1) begin
            hi_q    <= hi_nxt_q;
            lo_q    <= lo_nxt_q;
            cnt_q   <= 4'd0;
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    md_out = 32'd0;
    if (op == MD_MFHI) md_out = hi_q;
    else if (op == MD_MFLO) md_out = lo_q;
  end

  // The hazard unit should never let a HI/LO write or launch reach us while busy.
  a_no_op_while_busy : assert property (@(posedge clk) disable iff (!reset)
    !(busy && (start || (op == MD_MTHI) || (op == MD_MTLO))))
    else $warning("mult_div_unit: md op presented while busy was ignored");

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] md_out, hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
    .md_out(md_out), .hi(hi), .lo(lo)
  );

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, inout logic [31:0] h,
                                inout logic [31:0] l);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == MD_MULT) begin
      sp = sa * sb;
      h = sp[63:32]; l = sp[31:0];
    end else if (op == MD_MULTU) begin
      up = ua * ub;
      h = up[63:32]; l = up[31:0];
    end else if (op == MD_DIV && b != 0) begin
      sq = sa / sb; sr = sa % sb;
      h = sr[31:0]; l = sq[31:0];
    end else if (op == MD_DIVU && b != 0) begin
      uq = ua / ub; ur = ua % ub;
      h = ur[31:0]; l = uq[31:0];
    end else if (op == MD_MTHI) begin
      h = a;
    end else if (op == MD_MTLO) begin
      l = a;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int n;
    int exp_l;
    exp_l = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
    model(op, a, b, m_hi, m_lo);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    step();
    start = 1'b0; md_op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != exp_l) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, exp_l);
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL %s hilo: got %h/%h expected %h/%h", tag, hi, lo, m_hi, m_lo);
    end
    md_op = MD_MFHI; #1;
    checks++;
    if (md_out !== m_hi) begin
      failures++;
      $display("FAIL %s mfhi: got %h expected %h", tag, md_out, m_hi);
    end
    md_op = MD_MFLO; #1;
    checks++;
    if (md_out !== m_lo) begin
      failures++;
      $display("FAIL %s mflo: got %h expected %h", tag, md_out, m_lo);
    end
    md_op = MD_NONE; #1;
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v, input string tag);
    md_op = op; rs_val = v; #1;
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL %s early: got %h/%h expected %h/%h", tag, hi, lo, m_hi, m_lo);
    end
    step();
    md_op = MD_NONE;
    model(op, v, 32'd0, m_hi, m_lo);
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s write: got %h/%h busy=%b expected %h/%h busy=0",
               tag, hi, lo, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    md_op = MD_MFHI; #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h md_out=%h expected 0/0/0/0",
               busy, hi, lo, md_out);
    end
    md_op = MD_NONE;
    reset = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL mult_const: got %h/%h expected ffffffff/fffffffa", hi, lo);
    end
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
    checks++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL multu_const: got %h/%h expected 00000002/fffffffa", hi, lo);
    end
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL div_const: got %h/%h expected ffffffff/fffffffd", hi, lo);
    end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_ovf_const: got %h/%h expected 00000000/80000000", hi, lo);
    end
    do_mt(MD_MTHI, 32'h1234, "mthi");
    do_mt(MD_MTLO, 32'h5678, "mtlo");
    run_op(MD_DIVU, 32'd7, 32'd0, "divu_zero");
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      failures++;
      $display("FAIL divu_zero_const: got %h/%h expected 00001234/00005678", hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; md_op = MD_DIV; rs_val = 32'hFFFF_FF9C; rt_val = 32'd7;
    step();
    start = 1'b0; md_op = MD_NONE;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid busy_before: got %b expected 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid async: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    step();
    reset = 1'b1;
    repeat (12) step();
    md_op = MD_MFLO; #1;
    checks++;
    if (busy !== 1'b0 || md_out !== 32'd0 || hi !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid discard: got busy=%b mflo=%h hi=%h expected 0/0/0",
               busy, md_out, hi);
    end
    md_op = MD_NONE; #1;
  endtask

  task automatic test_illegal_while_busy();
    logic [31:0] old_hi, old_lo;
    int n;
    do_mt(MD_MTHI, 32'hCAFE_0001, "pre_mthi");
    do_mt(MD_MTLO, 32'hCAFE_0002, "pre_mtlo");
    old_hi = m_hi; old_lo = m_lo;
    model(MD_MULT, 32'd12345, 32'hFFFF_FD5A, m_hi, m_lo);
    start = 1'b1; md_op = MD_MULT; rs_val = 32'd12345; rt_val = 32'hFFFF_FD5A;
    step();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      start = 1'b0; md_op = MD_NONE;
      if (n == 1) begin
        start = 1'b1; md_op = MD_DIVU; rs_val = $urandom; rt_val = $urandom_range(1, 100);
      end else if (n == 2) begin
        md_op = MD_MTLO; rs_val = 32'hDEAD_BEEF;
      end else if (n == 3) begin
        md_op = MD_MFHI; #1;
        checks++;
        if (md_out !== old_hi) begin
          failures++;
          $display("FAIL busy_mfhi: got %h expected %h", md_out, old_hi);
        end
        md_op = MD_MFLO; #1;
        checks++;
        if (md_out !== old_lo) begin
          failures++;
          $display("FAIL busy_mflo: got %h expected %h", md_out, old_lo);
        end
        md_op = MD_NONE;
      end
      step();
    end
    start = 1'b0; md_op = MD_NONE;
    checks++;
    if (n != 5 || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL illegal_ignored: got cycles=%0d hilo=%h/%h expected 5 %h/%h",
               n, hi, lo, m_hi, m_lo);
    end
    step();
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL illegal_no_second_run: got busy=%b hilo=%h/%h expected 0 %h/%h",
               busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: op = MD_MULT;
        1: op = MD_MULTU;
        2: op = MD_DIV;
        3: op = MD_DIVU;
        4: op = MD_MTHI;
        default: op = MD_MTLO;
      endcase
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 17);
        default: b = $urandom;
      endcase
      if (op == MD_MTHI || op == MD_MTLO) do_mt(op, a, "rand_mt");
      else run_op(op, a, b, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd10, "b2b_divu");
    run_op(MD_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "b2b_mult");
    run_op(MD_DIV, 32'h0000_0064, 32'hFFFF_FFF9, "b2b_div");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_illegal_while_busy();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
